// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C state encoding and byte constants
package i2c_pkg;

    localparam int BYTE_BITS = 8;
    localparam logic [3:0] CNT_LAST = 4'(BYTE_BITS - 1);
    localparam logic [3:0] CNT_FULL = 4'(BYTE_BITS);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ADDR       = 3'd1,
        ADDR_ACK   = 3'd2,
        WRITE      = 3'd3,
        DATA_ACK   = 3'd4,
        READ       = 3'd5,
        MASTER_ACK = 3'd6,
        WAIT_STOP  = 3'd7
    } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizer with registered edge, START and STOP pulses
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_q;

    // Idle-high reset values keep a released bus from looking like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_q    <= 1'b1;
            sda      <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_q    <= scl_sync[1];
            sda      <= sda_sync[1];
            scl_rise <= scl_sync[1] & ~scl_q;
            scl_fall <= ~scl_sync[1] & scl_q;
            start    <= scl_sync[1] & scl_q & sda & ~sda_sync[1];
            stop     <= scl_sync[1] & scl_q & ~sda & sda_sync[1];
        end
    end

endmodule

// File: rtl/i2c_target_slave.sv
// rtl/i2c_target_slave.sv - I2C target with one-byte holding register, write and read support
module i2c_target_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h30,
    parameter logic [7:0] RESET_DATA = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL_in,
    input  logic       SDA_in,
    output logic       SDA_pull_low,
    output logic [7:0] reg_data,
    output logic       rx_valid,
    output logic       addressed
);

    logic       sda;
    logic       scl_rise;
    logic       scl_fall;
    logic       start;
    logic       stop;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] shift, shift_n;
    logic [7:0] data_n;
    logic       rw, rw_n;
    logic       pull, pull_n;
    logic       rxv_n;
    logic       addr_n;

    i2c_bus_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (SCL_in),
        .sda_in   (SDA_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    // Gate with rst so the bus is let go in the same cycle reset arrives.
    assign SDA_pull_low = pull & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            shift     <= 8'h00;
            rw        <= 1'b0;
            pull      <= 1'b0;
            reg_data  <= RESET_DATA;
            rx_valid  <= 1'b0;
            addressed <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shift     <= shift_n;
            rw        <= rw_n;
            pull      <= pull_n;
            reg_data  <= data_n;
            rx_valid  <= rxv_n;
            addressed <= addr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shift_n = shift;
        rw_n    = rw;
        pull_n  = pull;
        data_n  = reg_data;
        rxv_n   = 1'b0;
        addr_n  = addressed;
        if (start) begin
            state_n = ADDR;
            cnt_n   = 4'd0;
            pull_n  = 1'b0;
            addr_n  = 1'b0;
        end else if (stop) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
            pull_n  = 1'b0;
            addr_n  = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shift_n = {shift[6:0], sda};
                    if (cnt == CNT_LAST) begin
                        cnt_n   = 4'd0;
                        rw_n    = sda;
                        state_n = (shift[6:0] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
                // First fall starts the ACK, second fall (9th clock) ends it.
                ADDR_ACK: if (scl_fall) begin
                    if (!pull) begin
                        pull_n = 1'b1;
                    end else begin
                        addr_n = 1'b1;
                        cnt_n  = 4'd0;
                        if (rw) begin
                            state_n = READ;
                            pull_n  = ~reg_data[7];
                            shift_n = {reg_data[6:0], 1'b0};
                        end else begin
                            state_n = WRITE;
                            pull_n  = 1'b0;
                        end
                    end
                end
                WRITE: if (scl_rise) begin
                    shift_n = {shift[6:0], sda};
                    if (cnt == CNT_LAST) begin
                        cnt_n   = 4'd0;
                        data_n  = {shift[6:0], sda};
                        rxv_n   = 1'b1;
                        state_n = DATA_ACK;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
                DATA_ACK: if (scl_fall) begin
                    if (!pull) begin
                        pull_n = 1'b1;
                    end else begin
                        pull_n  = 1'b0;
                        state_n = WRITE;
                    end
                end
                READ: begin
                    if (scl_rise) begin
                        cnt_n = cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt == CNT_FULL) begin
                            cnt_n   = 4'd0;
                            pull_n  = 1'b0;
                            state_n = MASTER_ACK;
                        end else begin
                            pull_n  = ~shift[7];
                            shift_n = {shift[6:0], 1'b0};
                        end
                    end
                end
                // A fall here can only follow an ACKed 9th rise; NACK leaves on the rise.
                MASTER_ACK: begin
                    if (scl_rise) begin
                        if (sda) begin
                            state_n = WAIT_STOP;
                            addr_n  = 1'b0;
                        end
                    end else if (scl_fall) begin
                        state_n = READ;
                        cnt_n   = 4'd0;
                        pull_n  = ~reg_data[7];
                        shift_n = {reg_data[6:0], 1'b0};
                    end
                end
                WAIT_STOP: begin
                    pull_n = 1'b0;
                    addr_n = 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_slave.sv
// tb/tb_i2c_target_slave.sv - directed bench driving an open-drain bus into i2c_target_slave
module tb_i2c_target_slave;
    import i2c_pkg::*;

    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_wire;
    logic       sda_pull_low;
    logic [7:0] reg_data;
    logic       rx_valid;
    logic       addressed;

    int n_checks = 0;
    int n_pass = 0;
    int rx_count = 0;
    int rx_run = 0;
    int rx_run_max = 0;
    int pull_cycles = 0;
    logic [7:0] rx_last = 8'h00;

    assign sda_wire = sda_m & ~sda_pull_low;

    always #5 clk = ~clk;

    i2c_target_slave #(.SLAVE_ADDR(7'h30), .RESET_DATA(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .SCL_in       (scl_m),
        .SDA_in       (sda_wire),
        .SDA_pull_low (sda_pull_low),
        .reg_data     (reg_data),
        .rx_valid     (rx_valid),
        .addressed    (addressed)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_count = rx_count + 1;
            rx_last  = reg_data;
            rx_run   = rx_run + 1;
            if (rx_run > rx_run_max) rx_run_max = rx_run;
        end else begin
            rx_run = 0;
        end
        if (sda_pull_low) pull_cycles = pull_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_io(input logic b, output logic seen);
        wait_clk(Q); sda_m = b;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); seen = sda_wire;
        wait_clk(Q); scl_m = 1'b0;
    endtask

    task automatic bus_start();
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); sda_m = 1'b0;
        wait_clk(Q); scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(Q); sda_m = 1'b0;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(d[i], s);
        bit_io(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, s);
            d[i] = s;
        end
        bit_io(nack, s);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] rd;
        int         pull_snap;

        wait_clk(4);
        check("rst_pull", sda_pull_low, 1'b0);
        check("rst_reg", reg_data, 8'h00);
        check("rst_rxv", rx_valid, 1'b0);
        check("rst_addressed", addressed, 1'b0);
        check("rst_state", dut.state, IDLE);
        rst = 1'b0;
        wait_clk(4);

        // write 0x30+W, 0x0C
        bus_start();
        write_byte(8'h60, ack); check("w1_addr_ack", ack, 1'b0);
        write_byte(8'h0C, ack); check("w1_data_ack", ack, 1'b0);
        wait_clk(Q);
        check("w1_addressed", addressed, 1'b1);
        bus_stop();
        wait_clk(Q);
        check("w1_reg", reg_data, 8'h0C);
        check("w1_rx_count", rx_count, 1);
        check("w1_rx_last", rx_last, 8'h0C);
        check("w1_addressed_stop", addressed, 1'b0);
        check("w1_state_idle", dut.state, IDLE);

        // read 0x30+R, NACK
        bus_start();
        write_byte(8'h61, ack); check("r1_addr_ack", ack, 1'b0);
        read_byte(1'b1, rd);    check("r1_data", rd, 8'h0C);
        wait_clk(Q);
        check("r1_state_wait", dut.state, WAIT_STOP);
        check("r1_addressed", addressed, 1'b0);
        check("r1_pull_released", sda_pull_low, 1'b0);
        bus_stop();
        wait_clk(Q);
        check("r1_state_idle", dut.state, IDLE);

        // address mismatch 0x31+W
        pull_snap = pull_cycles;
        bus_start();
        write_byte(8'h62, ack); check("m_addr_nack", ack, 1'b1);
        write_byte(8'h55, ack); check("m_data_nack", ack, 1'b1);
        bus_stop();
        wait_clk(Q);
        check("m_pull_cycles", pull_cycles - pull_snap, 0);
        check("m_rx_count", rx_count, 1);
        check("m_reg", reg_data, 8'h0C);

        // two-byte write, repeated START, read with ACK then NACK
        bus_start();
        write_byte(8'h60, ack); check("w2_addr_ack", ack, 1'b0);
        write_byte(8'hA5, ack); check("w2_d0_ack", ack, 1'b0);
        wait_clk(Q);
        check("w2_reg_a5", reg_data, 8'hA5);
        write_byte(8'h3C, ack); check("w2_d1_ack", ack, 1'b0);
        wait_clk(Q);
        check("w2_rx_count", rx_count, 3);
        check("w2_reg", reg_data, 8'h3C);
        bus_start();
        write_byte(8'h61, ack); check("r2_addr_ack", ack, 1'b0);
        read_byte(1'b0, rd);    check("r2_data0", rd, 8'h3C);
        wait_clk(Q);
        check("r2_addressed", addressed, 1'b1);
        read_byte(1'b1, rd);    check("r2_data1", rd, 8'h3C);
        bus_stop();
        wait_clk(Q);
        check("r2_addressed_stop", addressed, 1'b0);

        // reset during the 5th data bit of a write
        bus_start();
        write_byte(8'h60, ack); check("rs_addr_ack", ack, 1'b0);
        for (int i = 0; i < 4; i++) bit_io(1'b1, s);
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(2);
        check("rs_addressed_pre", addressed, 1'b1);
        rst = 1'b1;
        wait_clk(1);
        check("rs_pull", sda_pull_low, 1'b0);
        check("rs_reg", reg_data, 8'h00);
        check("rs_addressed", addressed, 1'b0);
        rst = 1'b0;
        wait_clk(Q); scl_m = 1'b0;
        bus_start();
        write_byte(8'h60, ack); check("rs_w_addr_ack", ack, 1'b0);
        write_byte(8'h77, ack); check("rs_w_data_ack", ack, 1'b0);
        bus_stop();
        wait_clk(Q);
        check("rs_w_reg", reg_data, 8'h77);
        check("rs_w_rx_count", rx_count, 4);
        check("rs_w_rx_last", rx_last, 8'h77);
        check("rx_pulse_width", rx_run_max, 1);
        check("final_addressed", addressed, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
